// File: rtl/lcd_bus_arb_if.sv
// Bus bundle for lcd_bus_arb: both requester handshakes plus the LCD panel pins.
// master = the controller side, slave = requesters and panel side.
interface lcd_bus_arb_if #(
    parameter int DW = 24
);
    logic          h_valid;
    logic          h_rs;
    logic [DW-1:0] h_data;
    logic          h_ready;
    logic          e_valid;
    logic          e_rs;
    logic [DW-1:0] e_data;
    logic          e_ready;
    logic          lcd_cs;
    logic          lcd_rs;
    logic          lcd_wr;
    logic          lcd_rd;
    logic          lcd_rst;
    logic [DW-1:0] lcd_data;
    logic          init_done;
    logic          busy;

    modport master (
        input  h_valid, h_rs, h_data, e_valid, e_rs, e_data,
        output h_ready, e_ready, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst,
               lcd_data, init_done, busy
    );

    modport slave (
        output h_valid, h_rs, h_data, e_valid, e_rs, e_data,
        input  h_ready, e_ready, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst,
               lcd_data, init_done, busy
    );
endinterface

// File: rtl/lcd_bus_arb.sv
// 8080-style LCD write controller: panel reset sequence, two-requester arbitration, timed CS/RS/WR.
// Define LCD_ARB_FIXED_PRI_EN for fixed host priority instead of round-robin.
module lcd_bus_arb #(
    parameter int DW       = 24,
    parameter int T_SETUP  = 2,
    parameter int T_WR     = 4,
    parameter int T_HOLD   = 2,
    parameter int RST_LOW  = 16,
    parameter int RST_WAIT = 32
) (
    input  logic           clk,
    input  logic           rst,
    lcd_bus_arb_if.master  bus
);
    localparam logic [2:0] S_PRST   = 3'd0;
    localparam logic [2:0] S_PWAIT  = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_SETUP  = 3'd3;
    localparam logic [2:0] S_STROBE = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    localparam logic [7:0] L_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] L_WR    = 8'(T_WR - 1);
    localparam logic [7:0] L_HOLD  = 8'(T_HOLD - 1);
    localparam logic [7:0] L_RLOW  = 8'(RST_LOW - 1);
    localparam logic [7:0] L_RWAIT = 8'(RST_WAIT - 1);

    logic [2:0]    r_state;
    logic [7:0]    r_cnt;
    logic          r_cs;
    logic          r_wr;
    logic          r_lcd_rst;
    logic          r_rs;
    logic [DW-1:0] r_data;
    logic          r_init_done;

    logic [2:0]    w_nxt;
    logic [7:0]    w_cnt_nxt;
    logic          w_idle;
    logic          w_grant_h;
    logic          w_grant_e;
    logic          w_accept;
    logic          w_nxt_bus;

    assign w_idle = (r_state == S_IDLE);

`ifdef LCD_ARB_FIXED_PRI_EN
    assign w_grant_h = bus.h_valid;
`else
    // r_last: 0 = host was last grantee, 1 = engine; the other side wins a tie
    logic r_last;
    assign w_grant_h = bus.h_valid && (!bus.e_valid || r_last);
`endif
    assign w_grant_e = bus.e_valid && !w_grant_h;
    assign w_accept  = w_idle && (w_grant_h || w_grant_e);

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_PRST:   if (r_cnt == 8'd0) begin w_nxt = S_PWAIT; w_cnt_nxt = L_RWAIT; end
                      else w_cnt_nxt = r_cnt - 8'd1;
            S_PWAIT:  if (r_cnt == 8'd0) w_nxt = S_IDLE;
                      else w_cnt_nxt = r_cnt - 8'd1;
            S_IDLE:   if (w_accept) begin w_nxt = S_SETUP; w_cnt_nxt = L_SETUP; end
            S_SETUP:  if (r_cnt == 8'd0) begin w_nxt = S_STROBE; w_cnt_nxt = L_WR; end
                      else w_cnt_nxt = r_cnt - 8'd1;
            S_STROBE: if (r_cnt == 8'd0) begin w_nxt = S_HOLD; w_cnt_nxt = L_HOLD; end
                      else w_cnt_nxt = r_cnt - 8'd1;
            S_HOLD:   if (r_cnt == 8'd0) w_nxt = S_IDLE;
                      else w_cnt_nxt = r_cnt - 8'd1;
            default:  begin w_nxt = S_PRST; w_cnt_nxt = L_RLOW; end
        endcase
    end

    assign w_nxt_bus = (w_nxt == S_SETUP) || (w_nxt == S_STROBE) || (w_nxt == S_HOLD);

    // Pin drivers are registered from the next state so the panel never sees decode glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PRST;
            r_cnt       <= L_RLOW;
            r_cs        <= 1'b1;
            r_wr        <= 1'b1;
            r_lcd_rst   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cs      <= !w_nxt_bus;
            r_wr      <= (w_nxt != S_STROBE);
            r_lcd_rst <= (w_nxt != S_PRST);
            if (r_state == S_PWAIT && w_nxt == S_IDLE)
                r_init_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs   <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            r_rs   <= w_grant_h ? bus.h_rs   : bus.e_rs;
            r_data <= w_grant_h ? bus.h_data : bus.e_data;
        end
    end

`ifndef LCD_ARB_FIXED_PRI_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_last <= 1'b1;
        else if (w_accept) r_last <= w_grant_e;
    end
`endif

    assign bus.h_ready   = w_idle && w_grant_h;
    assign bus.e_ready   = w_idle && w_grant_e;
    assign bus.lcd_cs    = r_cs;
    assign bus.lcd_wr    = r_wr;
    assign bus.lcd_rd    = 1'b1;
    assign bus.lcd_rst   = r_lcd_rst;
    assign bus.lcd_rs    = r_rs;
    assign bus.lcd_data  = r_data;
    assign bus.init_done = r_init_done;
    assign bus.busy      = !w_idle;
endmodule

// File: tb/tb_lcd_bus_arb.sv
// Directed bench for lcd_bus_arb: reset sequence, host/engine writes, ties, early request, mid-write reset.
module tb_lcd_bus_arb;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    lcd_bus_arb_if #(.DW(DW)) bus ();

    lcd_bus_arb #(
        .DW(DW), .T_SETUP(2), .T_WR(4), .T_HOLD(2), .RST_LOW(16), .RST_WAIT(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Releases rst and walks the 48-cycle panel reset sequence; optionally raises a host request in P_WAIT.
    task automatic reset_seq(input bit early);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (early && k == 20) begin
                bus.h_valid = 1'b1;
                bus.h_rs    = 1'b1;
                bus.h_data  = 24'hABCDEF;
            end
            #1;
            chk("rst_seq_lcd_rst", 32'(bus.lcd_rst), 32'(k >= 16));
            chk("rst_seq_cs",      32'(bus.lcd_cs), 32'd1);
            chk("rst_seq_wr",      32'(bus.lcd_wr), 32'd1);
            chk("rst_seq_init",    32'(bus.init_done), 32'(k >= 48));
            if (k < 48) chk("rst_seq_no_ready", 32'(bus.h_ready), 32'd0);
        end
    endtask

    initial begin
        bus.h_valid = 1'b0; bus.h_rs = 1'b0; bus.h_data = '0;
        bus.e_valid = 1'b0; bus.e_rs = 1'b0; bus.e_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cs",   32'(bus.lcd_cs), 32'd1);
        chk("reset_wr",   32'(bus.lcd_wr), 32'd1);
        chk("reset_rd",   32'(bus.lcd_rd), 32'd1);
        chk("reset_rst",  32'(bus.lcd_rst), 32'd0);
        chk("reset_rs",   32'(bus.lcd_rs), 32'd0);
        chk("reset_data", 32'(bus.lcd_data), 32'd0);
        chk("reset_rdy",  32'({bus.h_ready, bus.e_ready}), 32'd0);
        chk("reset_init", 32'(bus.init_done), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd1);

        // Early request is accepted on the first IDLE cycle
        reset_seq(1'b1);
        chk("early_h_ready", 32'(bus.h_ready), 32'd1);
        chk("early_e_ready", 32'(bus.e_ready), 32'd0);

        // Single host write; an engine pulse while busy must leave no trace
        tick();
        bus.h_valid = 1'b0;
        #1;
        chk("hw_ready_drop", 32'(bus.h_ready), 32'd0);
        chk("hw_cs_c1",   32'(bus.lcd_cs), 32'd0);
        chk("hw_data_c1", 32'(bus.lcd_data), 32'hABCDEF);
        chk("hw_rs_c1",   32'(bus.lcd_rs), 32'd1);
        chk("hw_wr_c1",   32'(bus.lcd_wr), 32'd1);
        for (int k = 2; k <= 9; k++) begin
            tick();
            if (k == 4) begin bus.e_valid = 1'b1; bus.e_rs = 1'b0; bus.e_data = 24'h123456; end
            if (k == 7) bus.e_valid = 1'b0;
            #1;
            chk("hw_wr", 32'(bus.lcd_wr), 32'((k < 3) || (k > 6)));
            chk("hw_cs", 32'(bus.lcd_cs), 32'(k == 9));
            chk("hw_busy", 32'(bus.busy), 32'(k != 9));
            if (k == 4) chk("hw_e_ready_busy", 32'(bus.e_ready), 32'd0);
        end
        tick();
        chk("drop_no_cs",   32'(bus.lcd_cs), 32'd1);
        chk("drop_no_data", 32'(bus.lcd_data), 32'hABCDEF);

        // Engine-only write
        bus.e_valid = 1'b1; bus.e_rs = 1'b0; bus.e_data = 24'h5A5A5A;
        #1;
        chk("ew_e_ready", 32'(bus.e_ready), 32'd1);
        chk("ew_h_ready", 32'(bus.h_ready), 32'd0);
        tick();
        bus.e_valid = 1'b0;
        chk("ew_data", 32'(bus.lcd_data), 32'h5A5A5A);
        chk("ew_rs",   32'(bus.lcd_rs), 32'd0);
        chk("ew_cs",   32'(bus.lcd_cs), 32'd0);
        repeat (8) tick();
        chk("ew_idle_cs", 32'(bus.lcd_cs), 32'd1);

        // Mid-STROBE reset
        bus.h_valid = 1'b1; bus.h_rs = 1'b0; bus.h_data = 24'h0F0F0F;
        tick();
        bus.h_valid = 1'b0;
        repeat (3) tick();
        chk("mr_wr_low", 32'(bus.lcd_wr), 32'd0);
        rst = 1'b1;
        #1;
        chk("mr_wr",   32'(bus.lcd_wr), 32'd1);
        chk("mr_cs",   32'(bus.lcd_cs), 32'd1);
        chk("mr_rst",  32'(bus.lcd_rst), 32'd0);
        chk("mr_init", 32'(bus.init_done), 32'd0);
        @(posedge clk);
        reset_seq(1'b0);

        // Ties from a fresh reset
        bus.h_valid = 1'b1; bus.h_rs = 1'b0; bus.h_data = 24'h111111;
        bus.e_valid = 1'b1; bus.e_rs = 1'b1; bus.e_data = 24'h222222;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_h;
`ifdef LCD_ARB_FIXED_PRI_EN
            exp_h = 1'b1;
`else
            exp_h = (i % 2 == 0);
`endif
            chk("tie_h_ready", 32'(bus.h_ready), 32'(exp_h));
            chk("tie_e_ready", 32'(bus.e_ready), 32'(!exp_h));
            tick();
            chk("tie_data", 32'(bus.lcd_data), exp_h ? 32'h111111 : 32'h222222);
            chk("tie_rs",   32'(bus.lcd_rs), 32'(!exp_h));
            repeat (4) tick();
            chk("tie_mid_ready", 32'({bus.h_ready, bus.e_ready}), 32'd0);
            repeat (4) tick();
        end
        bus.h_valid = 1'b0;
        bus.e_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_bus_arb.md
# lcd_bus_arb

LCD 8080-style write controller that shares the LCD parallel bus between two requesters: the host path (FMC-derived writes) and an internal engine (e.g. a fill or refresh unit). It runs the panel hardware-reset sequence after system reset, arbitrates pending writes, and generates `lcd_cs`/`lcd_rs`/`lcd_wr` with programmable setup, strobe and hold lengths. It sits between the FMC/LCD translation logic and the panel pins, in the `freq_168` domain.

## Interface
Parameters:
- `DW`, 24, LCD data width.
- `T_SETUP`, 2, cycles from CS/RS/data valid to WR falling edge (1..255).
- `T_WR`, 4, cycles WR held low (1..255).
- `T_HOLD`, 2, cycles data/CS held after WR rising edge (1..255).
- `RST_LOW`, 16, cycles `lcd_rst` is held low after reset (1..255).
- `RST_WAIT`, 32, cycles waited after `lcd_rst` is released before the first write (1..255).

Ports:
- `clk` in 1 — system clock; single clock domain.
- `rst` in 1 — asynchronous, active-high reset.
- `h_valid` in 1 — host write request.
- `h_rs` in 1 — host register-select value (0 = command, 1 = data).
- `h_data` in DW — host write data.
- `h_ready` out 1 — host request accepted this cycle.
- `e_valid`, `e_rs`, `e_data`, `e_ready` — same as the four host signals, for the engine requester.
- `lcd_cs` out 1 — panel chip select, active-low.
- `lcd_rs` out 1 — panel register select.
- `lcd_wr` out 1 — panel write strobe, active-low.
- `lcd_rd` out 1 — panel read strobe; tied high (write-only controller).
- `lcd_rst` out 1 — panel reset, active-low.
- `lcd_data` out DW — panel data bus.
- `init_done` out 1 — panel reset sequence complete.
- `busy` out 1 — high in every state except IDLE.

## Operation
- **States:**
  - `P_RST`: `lcd_rst` = 0 for `RST_LOW` cycles → `P_WAIT`.
  - `P_WAIT`: `lcd_rst` = 1 for `RST_WAIT` cycles → `IDLE`; `init_done` rises on entry to `IDLE` and stays high until the next `rst`.
  - `IDLE`: if any valid → grant one requester → `SETUP`.
  - `SETUP` (`T_SETUP` cycles) → `STROBE` (`T_WR` cycles) → `HOLD` (`T_HOLD` cycles) → `IDLE`.
- **Handshake:**
  - In `IDLE`, the granted requester's ready = its valid (combinational). The transfer completes on valid && ready.
  - `rs` and `data` are captured into output registers on that edge.
  - Ready is 0 in all other states and for the non-granted requester.
  - Requesters must hold valid/rs/data until ready is seen.
- **Bus drive:**
  - `SETUP`/`STROBE`/`HOLD`: `lcd_cs` = 0, `lcd_rs`/`lcd_data` = captured values.
  - `lcd_wr` = 0 only in `STROBE`.
  - `IDLE`: `lcd_cs` = 1, `lcd_wr` = 1; `lcd_rs`/`lcd_data` hold their last values.
- **Arbitration:**
  - Round-robin. A one-bit `last` pointer records the last grantee.
  - On simultaneous valid, the requester that is not `last` wins.
  - `last` resets to "engine", so the host wins the first tie.
  - Only one requester is granted per transaction.
- **Counters:** a single 8-bit down-counter, loaded with (param − 1) on state entry. The state advances when the count reaches 0.
- **Reset values (asynchronous on `rst`):** state `P_RST`, `lcd_rst` = 0, `lcd_cs` = 1, `lcd_wr` = 1, `lcd_rd` = 1, `lcd_rs` = 0, `lcd_data` = 0, `h_ready` = `e_ready` = 0, `init_done` = 0, `busy` = 1.

## Timing
- Accept edge at cycle 0. `lcd_cs` falls and data is driven at cycle 1.
- `lcd_wr` falls at cycle 1+`T_SETUP` and rises at 1+`T_SETUP`+`T_WR`.
- `lcd_cs` rises at 1+`T_SETUP`+`T_WR`+`T_HOLD`. At that cycle (`IDLE`) the next request can be accepted.
- Minimum write period is `T_SETUP`+`T_WR`+`T_HOLD`+1 cycles. Defaults: 9 cycles, which is 53.6 ns at 168 MHz.
- The first write can be accepted `RST_LOW`+`RST_WAIT` cycles after `rst` deasserts.
- **Boundary conditions:**
  - A valid held through `P_RST`/`P_WAIT` is not accepted early.
  - A valid dropping before ready causes no transfer.
  - `rst` asserted mid-`STROBE` returns `lcd_wr`/`lcd_cs` high immediately. The in-flight write is lost and the panel reset sequence restarts.

## Configuration
- `LCD_ARB_FIXED_PRI_EN`:
  - Defined: fixed priority. The host always wins simultaneous requests and the `last` pointer is removed. The engine can starve while the host streams.
  - Undefined (default): round-robin as above.

## Test plan
- **Reset:** deassert `rst` with no requests.
  - `lcd_rst` = 0 for 16 cycles, then 1.
  - `init_done` = 1 after a further 32 cycles.
  - `lcd_cs`/`lcd_wr` stay 1 throughout.
- **Single host write:** `h_valid`=1, `h_rs`=1, `h_data`=0xABCDEF in `IDLE`.
  - `h_ready` pulses for 1 cycle.
  - `lcd_data`=0xABCDEF with `lcd_cs`=0 from cycle 1.
  - `lcd_wr` low in cycles 3–6.
  - `lcd_cs` high at cycle 9.
- **Tie:** both valid continuously, 4 writes.
  - Grants alternate host, engine, host, engine.
  - One accept every 9 cycles.
  - With `LCD_ARB_FIXED_PRI_EN`: all 4 grants go to the host.
- **Early request:** host valid asserted during `P_WAIT`.
  - No `h_ready` before `init_done`.
  - Accepted on the first `IDLE` cycle.
- **Mid-write reset:** `rst` pulsed during `STROBE`.
  - Same cycle: `lcd_wr`=1, `lcd_cs`=1, `lcd_rst`=0, `init_done`=0.
  - The full reset sequence repeats.
